// File: rtl/header_rx.sv
// Block-header receiver: assembles HEADER_BYTES UART bytes into one wide word,
// with a level-ready clear handshake, mid-header timeout and overrun reporting.
module header_rx #(
  parameter int HEADER_BYTES   = 80,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [7:0]                rx_data,
  input  logic                      rx_rdy,
  output logic                      rx_rdy_clr,
  input  logic                      header_ack,
  output logic [8*HEADER_BYTES-1:0] header_data,
  output logic                      header_valid,
  output logic [6:0]                byte_count,
  output logic                      timeout_err,
  output logic                      overrun
);

  localparam int SW = 8 * HEADER_BYTES;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [6:0]    HB_LAST = 7'(HEADER_BYTES);
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] shadow_q, shadow_d;
  logic [SW-1:0] header_data_q, header_data_d;
  logic          header_valid_q, header_valid_d;
  logic [6:0]    byte_count_q, byte_count_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          clr_pend_q, clr_pend_d;
  logic          rx_rdy_clr_q, rx_rdy_clr_d;
  logic          timeout_err_q, timeout_err_d;
  logic          overrun_q, overrun_d;

  logic          present;
  logic          take;
  logic          hs_start;
  logic [SW-1:0] shadow_shift;
  logic [6:0]    count_inc;

  assign present      = rx_rdy && !clr_pend_q;
  assign shadow_shift = {shadow_q[SW-9:0], rx_data};
  assign count_inc    = byte_count_q + 7'd1;

  always_comb begin
    state_d        = state_q;
    shadow_d       = shadow_q;
    header_data_d  = header_data_q;
    header_valid_d = header_valid_q;
    byte_count_d   = byte_count_q;
    timer_d        = timer_q;
    clr_pend_d     = clr_pend_q;
    rx_rdy_clr_d   = rx_rdy_clr_q;
    timeout_err_d  = 1'b0;
    overrun_d      = 1'b0;
    take           = 1'b0;
    hs_start       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (present) begin
          take     = 1'b1;
          hs_start = 1'b1;
        end
      end
      RECV: begin
        if (present) begin
          take     = 1'b1;
          hs_start = 1'b1;
        end else if (timer_q == T_LAST) begin
          state_d       = IDLE;
          byte_count_d  = 7'd0;
          shadow_d      = '0;
          timer_d       = '0;
          timeout_err_d = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      DONE: begin
        // Ack wins: a byte arriving with it is left for IDLE to take.
        if (header_ack) begin
          state_d        = IDLE;
          header_valid_d = 1'b0;
          byte_count_d   = 7'd0;
          shadow_d       = '0;
        end else if (present) begin
          hs_start  = 1'b1;
          overrun_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (take) begin
      shadow_d     = shadow_shift;
      byte_count_d = count_inc;
      timer_d      = '0;
      state_d      = RECV;
      if (count_inc == HB_LAST) begin
        header_data_d  = shadow_shift;
        header_valid_d = 1'b1;
        state_d        = DONE;
      end
    end

    if (hs_start) begin
      clr_pend_d   = 1'b1;
      rx_rdy_clr_d = 1'b1;
    end else if (clr_pend_q && !rx_rdy) begin
      clr_pend_d   = 1'b0;
      rx_rdy_clr_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      shadow_q       <= '0;
      header_data_q  <= '0;
      header_valid_q <= 1'b0;
      byte_count_q   <= 7'd0;
      timer_q        <= '0;
      clr_pend_q     <= 1'b0;
      rx_rdy_clr_q   <= 1'b0;
      timeout_err_q  <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      shadow_q       <= shadow_d;
      header_data_q  <= header_data_d;
      header_valid_q <= header_valid_d;
      byte_count_q   <= byte_count_d;
      timer_q        <= timer_d;
      clr_pend_q     <= clr_pend_d;
      rx_rdy_clr_q   <= rx_rdy_clr_d;
      timeout_err_q  <= timeout_err_d;
      overrun_q      <= overrun_d;
    end
  end

  assign rx_rdy_clr   = rx_rdy_clr_q;
  assign header_data  = header_data_q;
  assign header_valid = header_valid_q;
  assign byte_count   = byte_count_q;
  assign timeout_err  = timeout_err_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_header_rx.sv
// Bench for header_rx: directed sequences, a vector table and a
// randomized byte stream checked against a transaction-level model.
module tb_header_rx;

  localparam int HB = 80;
  localparam int TO = 100;
  localparam int DW = 8 * HB;

  logic          clock = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_rdy;
  logic          rx_rdy_clr;
  logic          header_ack;
  logic [DW-1:0] header_data;
  logic          header_valid;
  logic [6:0]    byte_count;
  logic          timeout_err;
  logic          overrun;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    bit         is_ack;
    logic [7:0] data;
    logic [6:0] exp_cnt;
    logic       exp_vld;
    logic       exp_ovr;
  } vec_t;

  vec_t tbl[6];

  header_rx #(
    .HEADER_BYTES  (HB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_rdy      (rx_rdy),
    .rx_rdy_clr  (rx_rdy_clr),
    .header_ack  (header_ack),
    .header_data (header_data),
    .header_valid(header_valid),
    .byte_count  (byte_count),
    .timeout_err (timeout_err),
    .overrun     (overrun)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    rx_rdy     = 1'b0;
    header_ack = 1'b0;
    rx_data    = 8'h00;
    step();
    step();
    reset = 1'b0;
  endtask

  // UART-side model: hold rx_rdy until the clear request, then drop it.
  task automatic send(input logic [7:0] b, output logic ovr,
                      output logic vld);
    ovr     = 1'b0;
    rx_data = b;
    rx_rdy  = 1'b1;
    for (int n = 0; n < 10; n++) begin
      step();
      ovr = ovr | overrun;
      if (rx_rdy_clr) break;
    end
    vld = header_valid;
    check("clr_raise", DW'(rx_rdy_clr), DW'(1));
    rx_rdy = 1'b0;
    step();
    ovr = ovr | overrun;
    check("clr_drop", DW'(rx_rdy_clr), DW'(0));
  endtask

  function automatic logic [DW-1:0] pack(input logic [7:0] q[$]);
    logic [DW-1:0] r;
    r = '0;
    foreach (q[i]) r = (r << 8) | DW'(q[i]);
    return r;
  endfunction

  initial begin
    logic          ovr, vld, bad;
    logic [DW-1:0] hdr;
    logic [7:0]    q[$];
    int            n, extra;

    tbl[0] = '{1'b0, 8'hA1, 7'd80, 1'b1, 1'b1};
    tbl[1] = '{1'b0, 8'hA2, 7'd80, 1'b1, 1'b1};
    tbl[2] = '{1'b0, 8'hA3, 7'd80, 1'b1, 1'b1};
    tbl[3] = '{1'b1, 8'h00, 7'd0,  1'b0, 1'b0};
    tbl[4] = '{1'b0, 8'h11, 7'd1,  1'b0, 1'b0};
    tbl[5] = '{1'b0, 8'h22, 7'd2,  1'b0, 1'b0};

    do_reset();
    check("rst_clr",  DW'(rx_rdy_clr), DW'(0));
    check("rst_vld",  DW'(header_valid), DW'(0));
    check("rst_cnt",  DW'(byte_count), DW'(0));
    check("rst_to",   DW'(timeout_err), DW'(0));
    check("rst_ovr",  DW'(overrun), DW'(0));
    check("rst_data", header_data, DW'(0));

    // Full header 0x00..0x4F
    q = {};
    for (int i = 0; i < HB; i++) begin
      q.push_back(8'(i));
      send(8'(i), ovr, vld);
      if (i == HB - 2) check("vld_early", DW'(vld), DW'(0));
      if (i == HB - 1) check("vld_at_last", DW'(vld), DW'(1));
    end
    check("hdr_cnt", DW'(byte_count), DW'(80));
    check("hdr_msb", DW'(header_data[DW-1 -: 8]), DW'(8'h00));
    check("hdr_lsb", DW'(header_data[7:0]), DW'(8'h4F));
    check("hdr_all", header_data, pack(q));
    hdr = pack(q);

    // Overruns, ack, restart
    foreach (tbl[i]) begin
      if (tbl[i].is_ack) begin
        header_ack = 1'b1;
        step();
        header_ack = 1'b0;
        ovr = overrun;
      end else begin
        send(tbl[i].data, ovr, vld);
      end
      check($sformatf("tbl%0d_cnt", i), DW'(byte_count), DW'(tbl[i].exp_cnt));
      check($sformatf("tbl%0d_vld", i), DW'(header_valid), DW'(tbl[i].exp_vld));
      check($sformatf("tbl%0d_ovr", i), DW'(ovr), DW'(tbl[i].exp_ovr));
      check($sformatf("tbl%0d_data", i), header_data, hdr);
    end

    // Timeout after 10 bytes
    do_reset();
    for (int i = 0; i < 10; i++) send(8'(8'h30 + i), ovr, vld);
    n = 1;
    while (!timeout_err && n < 200) begin
      step();
      n++;
    end
    check("to_delay", DW'(n), DW'(TO));
    check("to_cnt", DW'(byte_count), DW'(0));
    step();
    check("to_pulse", DW'(timeout_err), DW'(0));
    send(8'h77, ovr, vld);
    check("to_next", DW'(byte_count), DW'(1));

    // Ack and byte together in DONE
    for (int i = 1; i < HB; i++) send(8'(i), ovr, vld);
    check("sim_done", DW'(header_valid), DW'(1));
    rx_data    = 8'h5A;
    rx_rdy     = 1'b1;
    header_ack = 1'b1;
    step();
    header_ack = 1'b0;
    check("sim_ovr", DW'(overrun), DW'(0));
    check("sim_noclr", DW'(rx_rdy_clr), DW'(0));
    check("sim_vld", DW'(header_valid), DW'(0));
    step();
    check("sim_cnt", DW'(byte_count), DW'(1));
    check("sim_clr", DW'(rx_rdy_clr), DW'(1));
    check("sim_ovr2", DW'(overrun), DW'(0));
    rx_rdy = 1'b0;
    step();

    // Reset mid-handshake with rx_rdy held
    for (int i = 2; i < 40; i++) send(8'(i), ovr, vld);
    rx_data = 8'hC4;
    rx_rdy  = 1'b1;
    step();
    check("mid_cnt", DW'(byte_count), DW'(40));
    check("mid_clr", DW'(rx_rdy_clr), DW'(1));
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mr_cnt", DW'(byte_count), DW'(0));
    check("mr_clr", DW'(rx_rdy_clr), DW'(0));
    check("mr_vld", DW'(header_valid), DW'(0));
    check("mr_flags", DW'({timeout_err, overrun}), DW'(0));
    check("mr_data", header_data, DW'(0));
    step();
    check("mr_take", DW'(byte_count), DW'(1));
    check("mr_clr2", DW'(rx_rdy_clr), DW'(1));
    rx_rdy = 1'b0;
    step();

    // rx_rdy held for 20 cycles
    rx_data = 8'h99;
    rx_rdy  = 1'b1;
    bad     = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (byte_count != 7'd2 || !rx_rdy_clr) bad = 1'b1;
    end
    check("hold_stable", DW'(bad), DW'(0));
    rx_rdy = 1'b0;
    step();
    check("hold_clr", DW'(rx_rdy_clr), DW'(0));
    check("hold_cnt", DW'(byte_count), DW'(2));

    // Randomized stream vs. byte-queue model
    do_reset();
    for (int h = 0; h < 3; h++) begin
      q = {};
      for (int i = 0; i < HB; i++) begin
        logic [7:0] b;
        b = 8'($urandom);
        q.push_back(b);
        repeat ($urandom_range(0, 3)) step();
        send(b, ovr, vld);
        check($sformatf("rnd%0d_cnt", h), DW'(byte_count), DW'(q.size()));
      end
      check($sformatf("rnd%0d_vld", h), DW'(header_valid), DW'(1));
      check($sformatf("rnd%0d_hdr", h), header_data, pack(q));
      extra = $urandom_range(0, 2);
      for (int e = 0; e < extra; e++) begin
        send(8'($urandom), ovr, vld);
        check($sformatf("rnd%0d_ovr", h), DW'(ovr), DW'(1));
        check($sformatf("rnd%0d_keep", h), header_data, pack(q));
      end
      header_ack = 1'b1;
      step();
      header_ack = 1'b0;
      check($sformatf("rnd%0d_ack_vld", h), DW'(header_valid), DW'(0));
      check($sformatf("rnd%0d_ack_cnt", h), DW'(byte_count), DW'(0));
      check($sformatf("rnd%0d_retain", h), header_data, pack(q));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
